// File: rtl/pulse_rate_meter.sv
// Windowed pulse counter with a valid/ready result slot.
// Optional threshold alarm when PULSE_RATE_ALARM_EN is defined.
module pulse_rate_meter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             cnt_sat,
  output logic             overrun,
`ifdef PULSE_RATE_ALARM_EN
  input  logic [CNT_W-1:0] thresh,
  output logic             alarm,
`endif
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIN_W-1:0] timer;
  logic [CNT_W-1:0] acc;
  logic             sat_f;

  logic [WIN_W-1:0] win_m1;
  logic             acc_full;
  logic [CNT_W-1:0] acc_add;
  logic             sat_add;
  logic             win_end;
  logic             accept;
  logic             load;

  // win_len of 0 behaves as a one-cycle window
  assign win_m1   = (win_len == '0) ? '0 : win_len - WIN_W'(1);
  assign acc_full = (acc == CNT_MAX);
  assign acc_add  = (pulse_in && !acc_full) ? acc + CNT_W'(1) : acc;
  assign sat_add  = sat_f | (pulse_in & acc_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (enable)  state_nxt = RUN;
      RUN:  if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == RUN);
    win_end = (state == RUN) && enable && (timer == '0);
    accept  = cnt_valid && cnt_ready;
    load    = win_end && (!cnt_valid || cnt_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      acc   <= '0;
      sat_f <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            timer <= win_m1;
            acc   <= '0;
            sat_f <= 1'b0;
          end
        end
        RUN: begin
          if (!enable) begin
            timer <= '0;
            acc   <= '0;
            sat_f <= 1'b0;
          end else if (timer != '0) begin
            timer <= timer - WIN_W'(1);
            acc   <= acc_add;
            sat_f <= sat_add;
          end else begin
            timer <= win_m1;
            acc   <= '0;
            sat_f <= 1'b0;
          end
        end
        default: begin
          timer <= '0;
          acc   <= '0;
          sat_f <= 1'b0;
        end
      endcase
    end
  end

  // Full slot keeps the old result; the new one is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_data  <= '0;
      cnt_valid <= 1'b0;
      cnt_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        cnt_data  <= acc_add;
        cnt_sat   <= sat_add;
        cnt_valid <= 1'b1;
      end else if (win_end) begin
        overrun <= 1'b1;
      end else if (accept) begin
        cnt_valid <= 1'b0;
      end
    end
  end

`ifdef PULSE_RATE_ALARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (state == RUN && !enable) begin
      alarm <= 1'b0;
    end else if (win_end) begin
      alarm <= (thresh != '0) && (acc_add >= thresh);
    end
  end
`endif

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Scoreboard bench for pulse_rate_meter.
// Narrow counter so saturation is reachable quickly.
module tb_pulse_rate_meter;

  localparam int CW = 4;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [WW-1:0] win_len = '0;
  logic          pulse_in = 1'b0;
  logic [CW-1:0] cnt_data;
  logic          cnt_valid;
  logic          cnt_ready = 1'b0;
  logic          cnt_sat;
  logic          overrun;
  logic          busy;
`ifdef PULSE_RATE_ALARM_EN
  logic [CW-1:0] thresh = '0;
  logic          alarm;
`endif

  int pass_cnt = 0;
  int total = 0;

  logic [CW:0] exp_q[$];
  logic [CW:0] e;

  pulse_rate_meter #(.CNT_W(CW), .WIN_W(WW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .win_len(win_len),
    .pulse_in(pulse_in),
    .cnt_data(cnt_data),
    .cnt_valid(cnt_valid),
    .cnt_ready(cnt_ready),
    .cnt_sat(cnt_sat),
    .overrun(overrun),
`ifdef PULSE_RATE_ALARM_EN
    .thresh(thresh),
    .alarm(alarm),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p);
    pulse_in = p;
    tick();
  endtask

  // np pulses first, then idle cycles, n edges total
  task automatic run_win(input int n, input int np);
    for (int i = 0; i < n; i++) drive(i < np);
  endtask

  task automatic test_reset();
    #12;
    total++; if (cnt_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", cnt_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (cnt_data !== '0) $display("FAIL rst_data got %0d exp 0", cnt_data); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    win_len = 4;
    enable = 1'b1;
    exp_q.push_back({1'b0, 4'd2});
    drive(1'b1);
    total++; if (busy !== 1'b1) $display("FAIL basic_busy0 got %b exp 1", busy); else pass_cnt++;
    drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    total++; if (cnt_valid !== 1'b0) $display("FAIL basic_early got %b exp 0", cnt_valid); else pass_cnt++;
    drive(1'b0);
    e = exp_q.pop_front();
    total++; if (cnt_valid !== 1'b1) $display("FAIL basic_valid got %b exp 1", cnt_valid); else pass_cnt++;
    total++; if (cnt_data !== e[CW-1:0]) $display("FAIL basic_data got %0d exp %0d", cnt_data, e[CW-1:0]); else pass_cnt++;
    total++; if (cnt_sat !== e[CW]) $display("FAIL basic_sat got %b exp %b", cnt_sat, e[CW]); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else pass_cnt++;
    enable = 1'b0;
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
    total++; if (cnt_valid !== 1'b0) $display("FAIL basic_clear got %b exp 0", cnt_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL basic_idle got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    win_len = 3;
    cnt_ready = 1'b0;
    enable = 1'b1;
    drive(1'b0);
    exp_q.push_back({1'b0, 4'd1});
    drive(1'b1); drive(1'b0); drive(1'b0);
    e = exp_q.pop_front();
    total++; if (cnt_data !== e[CW-1:0]) $display("FAIL b2b_w1 got %0d exp %0d", cnt_data, e[CW-1:0]); else pass_cnt++;
    total++; if (overrun !== 1'b0) $display("FAIL b2b_w1_ovr got %b exp 0", overrun); else pass_cnt++;
    drive(1'b0); drive(1'b1); drive(1'b0);
    total++; if (overrun !== 1'b1) $display("FAIL b2b_ovr got %b exp 1", overrun); else pass_cnt++;
    total++; if (cnt_data !== 4'd1) $display("FAIL b2b_hold got %0d exp 1", cnt_data); else pass_cnt++;
    exp_q.push_back({1'b0, 4'd1});
    drive(1'b1);
    total++; if (overrun !== 1'b0) $display("FAIL b2b_ovr_pulse got %b exp 0", overrun); else pass_cnt++;
    drive(1'b0);
    cnt_ready = 1'b1;
    drive(1'b0);
    cnt_ready = 1'b0;
    e = exp_q.pop_front();
    total++; if (overrun !== 1'b0) $display("FAIL b2b_acc_ovr got %b exp 0", overrun); else pass_cnt++;
    total++; if (cnt_valid !== 1'b1) $display("FAIL b2b_acc_valid got %b exp 1", cnt_valid); else pass_cnt++;
    total++; if (cnt_data !== e[CW-1:0]) $display("FAIL b2b_w3 got %0d exp %0d", cnt_data, e[CW-1:0]); else pass_cnt++;
    enable = 1'b0;
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
  endtask

  task automatic test_saturation();
    win_len = 20;
    cnt_ready = 1'b1;
    enable = 1'b1;
    exp_q.push_back({1'b1, 4'd15});
    exp_q.push_back({1'b0, 4'd0});
    drive(1'b1);
    run_win(20, 20);
    e = exp_q.pop_front();
    total++; if (cnt_data !== e[CW-1:0]) $display("FAIL sat_data got %0d exp %0d", cnt_data, e[CW-1:0]); else pass_cnt++;
    total++; if (cnt_sat !== e[CW]) $display("FAIL sat_flag got %b exp %b", cnt_sat, e[CW]); else pass_cnt++;
    run_win(20, 0);
    e = exp_q.pop_front();
    total++; if (cnt_valid !== 1'b1) $display("FAIL sat2_valid got %b exp 1", cnt_valid); else pass_cnt++;
    total++; if (cnt_data !== e[CW-1:0]) $display("FAIL sat2_data got %0d exp %0d", cnt_data, e[CW-1:0]); else pass_cnt++;
    total++; if (cnt_sat !== e[CW]) $display("FAIL sat2_flag got %b exp %b", cnt_sat, e[CW]); else pass_cnt++;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_win_zero();
    logic p;
    win_len = 0;
    cnt_ready = 1'b1;
    enable = 1'b1;
    drive(1'b0);
    for (int i = 0; i < 5; i++) begin
      p = ((i % 2) == 0);
      exp_q.push_back({1'b0, 3'd0, p});
      drive(p);
      e = exp_q.pop_front();
      total++; if (cnt_valid !== 1'b1) $display("FAIL w0_valid[%0d] got %b exp 1", i, cnt_valid); else pass_cnt++;
      total++; if (cnt_data !== e[CW-1:0]) $display("FAIL w0_data[%0d] got %0d exp %0d", i, cnt_data, e[CW-1:0]); else pass_cnt++;
    end
    enable = 1'b0;
    cnt_ready = 1'b0;
    tick();
  endtask

  task automatic test_abort_reset();
    total++; if (cnt_data !== 4'd1) $display("FAIL ab_pre got %0d exp 1", cnt_data); else pass_cnt++;
    win_len = 8;
    enable = 1'b1;
    drive(1'b0);
    drive(1'b1); drive(1'b1); drive(1'b1); drive(1'b0);
    enable = 1'b0;
    drive(1'b1);
    total++; if (busy !== 1'b0) $display("FAIL ab_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (cnt_data !== 4'd1) $display("FAIL ab_data got %0d exp 1", cnt_data); else pass_cnt++;
    total++; if (cnt_valid !== 1'b1) $display("FAIL ab_valid got %b exp 1", cnt_valid); else pass_cnt++;
    run_win(12, 6);
    total++; if (cnt_data !== 4'd1) $display("FAIL ab_idle_data got %0d exp 1", cnt_data); else pass_cnt++;
    total++; if (overrun !== 1'b0) $display("FAIL ab_idle_ovr got %b exp 0", overrun); else pass_cnt++;
    enable = 1'b1;
    drive(1'b0);
    drive(1'b1); drive(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (cnt_data !== '0) $display("FAIL arst_data got %0d exp 0", cnt_data); else pass_cnt++;
    total++; if (cnt_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", cnt_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL arst_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (cnt_sat !== 1'b0) $display("FAIL arst_sat got %b exp 0", cnt_sat); else pass_cnt++;
    total++; if (overrun !== 1'b0) $display("FAIL arst_ovr got %b exp 0", overrun); else pass_cnt++;
    enable = 1'b0;
    pulse_in = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

`ifdef PULSE_RATE_ALARM_EN
  task automatic test_alarm();
    logic exp_al[4];
    int   np[4];
    np = '{2, 3, 4, 4};
    exp_al = '{1'b0, 1'b1, 1'b1, 1'b0};
    win_len = 5;
    cnt_ready = 1'b1;
    enable = 1'b1;
    drive(1'b0);
    for (int i = 0; i < 4; i++) begin
      thresh = (i == 3) ? 4'd0 : 4'd3;
      run_win(5, np[i]);
      total++; if (cnt_data !== 4'(np[i])) $display("FAIL al_data[%0d] got %0d exp %0d", i, cnt_data, np[i]); else pass_cnt++;
      total++; if (alarm !== exp_al[i]) $display("FAIL al_alarm[%0d] got %b exp %b", i, alarm, exp_al[i]); else pass_cnt++;
    end
    thresh = 4'd3;
    run_win(5, 4);
    enable = 1'b0;
    tick();
    total++; if (alarm !== 1'b0) $display("FAIL al_idle got %b exp 0", alarm); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_win_zero();
    test_abort_reset();
`ifdef PULSE_RATE_ALARM_EN
    test_alarm();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
